// File: rtl/operand_issue.sv
// Operand fetch/issue: R x N register file with write-back bypass and a pending-destination scoreboard.
// Latency: op accepted at edge k drives A/B/F/out_rd from edge k; output holds while out_ready=0 and in_ready drops on a hazard or a full output slot.
module operand_issue #(
  parameter int N = 32,
  parameter int R = 8,
  localparam int RW = $clog2(R)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_f,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic [RW-1:0] in_rd,
  input  logic          in_imm_en,
  input  logic [N-1:0]  in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic [2:0]    F,
  output logic [RW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [N-1:0]  wb_data,
  input  logic          wb_ovf,
  output logic          ovf_sticky
);

  logic [N-1:0] regs [R];
  logic [R-1:0] pending;
  logic [R-1:0] wb_clr;
  logic [R-1:0] acc_set;
  logic [R-1:0] eff_pend;
  logic [N-1:0] rs1_val;
  logic [N-1:0] rs2_val;
  logic [N-1:0] b_val;
  logic         stall;
  logic         accept;

  // A write-back this cycle both bypasses its data and releases its scoreboard bit.
  always_comb begin
    wb_clr = '0;
    if (wb_en && wb_rd != '0) wb_clr[wb_rd] = 1'b1;
  end

  assign eff_pend = pending & ~wb_clr;

  always_comb begin
    rs1_val = '0;
    if (in_rs1 != '0) rs1_val = (wb_en && wb_rd == in_rs1) ? wb_data : regs[in_rs1];
    rs2_val = '0;
    if (in_rs2 != '0) rs2_val = (wb_en && wb_rd == in_rs2) ? wb_data : regs[in_rs2];
  end

  assign b_val = in_imm_en ? in_imm : rs2_val;

  assign stall = in_valid && (eff_pend[in_rs1] ||
                              (!in_imm_en && eff_pend[in_rs2]) ||
                              eff_pend[in_rd]);

  assign in_ready = (!out_valid || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_set = '0;
    if (accept && in_rd != '0) acc_set[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < R; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;
      // Set after clear so a same-cycle issue to the written register stays pending.
      pending <= (pending & ~wb_clr) | acc_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      F         <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      A         <= rs1_val;
      B         <= b_val;
      F         <= in_f;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_sticky <= 1'b0;
    else if (wb_en && wb_ovf) ovf_sticky <= 1'b1;
  end

endmodule

// File: doc/operand_issue.md
# operand_issue

Operand-fetch and issue stage directly upstream of the ALU. Holds an R-entry × N-bit register file and accepts decoded operations over a valid/ready handshake. Reads and bypasses operands, tracks in-flight destinations with a scoreboard, and presents registered A, B and F to the ALU. The ALU result (Y, Ovf) returns on the write-back port and is written into the register file.

## Interface
- N, 32, datapath width; matches ALU A/B/Y width
- R, 8, register count (power of two, ≥2); RW = $clog2(R)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  decoded op present
- in_ready  output  1  stage accepts op this cycle
- in_f  input  3  ALU function code (passed to F)
- in_rs1  input  RW  source register for A
- in_rs2  input  RW  source register for B
- in_rd  input  RW  destination register
- in_imm_en  input  1  1: B = in_imm, rs2 ignored
- in_imm  input  N  immediate operand
- out_valid  output  1  A/B/F/out_rd valid toward ALU stage
- out_ready  input  1  downstream consumes op this cycle
- A  output  N  ALU operand A (registered)
- B  output  N  ALU operand B (registered)
- F  output  3  ALU function (registered)
- out_rd  output  RW  destination carried with op
- wb_en  input  1  write-back strobe
- wb_rd  input  RW  write-back register
- wb_data  input  N  write-back value (ALU Y)
- wb_ovf  input  1  ALU Ovf for this write-back
- ovf_sticky  output  1  set by any wb_en with wb_ovf=1

## Operation
- Register 0 always reads 0. Writes to register 0 are discarded. Register 0 is never marked pending.
- Write-back: on a clk edge with wb_en=1 and wb_rd≠0, regs[wb_rd] ← wb_data and pending[wb_rd] ← 0.
- Operand read (combinational, same cycle as accept), for rs1 and rs2:
  - rs=0 → 0.
  - Else if wb_en and wb_rd=rs → wb_data (bypass).
  - Else regs[rs].
- B source: in_imm when in_imm_en=1, else the rs2 value.
- Hazard:
  - A register is effectively pending when pending[r]=1 and it is not cleared by a write-back this cycle.
  - stall = in_valid AND (rs1 effectively pending OR (¬in_imm_en AND rs2 effectively pending) OR rd effectively pending).
- in_ready = (¬out_valid OR out_ready) AND ¬stall. Computed combinationally; in_ready may depend on in_valid.
- Accept = in_valid AND in_ready. On accept:
  - A, B, F, out_rd load.
  - out_valid ← 1.
  - pending[in_rd] ← 1 if in_rd≠0.
- If write-back clears and accept sets the same register in one cycle, set wins.
- If out_valid AND out_ready AND no accept: out_valid ← 0. A/B/F/out_rd hold their last values.
- While out_valid=1 and out_ready=0, A/B/F/out_rd are stable.
- ovf_sticky ← 1 on any edge with wb_en=1 and wb_ovf=1 (including wb_rd=0). It is cleared only by reset.
- No arithmetic in this block. All operand widths are N with no extension.

## Timing
- Reset (asynchronous, immediate on assertion) clears:
  - out_valid, A, B, F, out_rd, ovf_sticky
  - all regs and all pending bits
- After reset, in_ready=1 (given no stall).
- Reset mid-operation discards the held op and all scoreboard state. Write-back data arriving during reset is ignored.
- Latency: op accepted at edge k → out_valid=1 with its A/B/F from edge k.
- Throughput: one op per cycle when out_ready=1 and there are no hazards.
- A dependent op issues in the same cycle its producer's wb_en is seen, using the bypassed value. Zero-bubble after write-back.
- Write-back and accept in the same cycle to different registers are independent.
- The register file has no read-during-write hazard other than the bypass above. The stored value is updated at the edge.

## Test plan
- Reset, wb r1=5, then issue rs1=1, rs2=0, in_f=3'b010, rd=2 → next cycle out_valid=1, A=5, B=0, F=010, out_rd=2. in_ready=0 for a later op reading r2 until wb r2.
- Bypass: same cycle wb_en, wb_rd=4, wb_data=0x1234 and issue rs1=4, rs2=4 → A=B=0x1234. regs[4]=0x1234 afterward.
- RAW stall: issue rd=3, then op with rs1=3 held in_valid → in_ready=0 for 3 cycles. Then wb r3=0xAA → accepted that cycle, A=0xAA next cycle.
- Backpressure: out_valid=1, out_ready=0 for 2 cycles with new op pending → A/B/F unchanged, in_ready=0. out_ready=1 → new op loads next edge.
- r0/immediate:
  - wb r0=0xFFFF, then issue rs1=0, imm_en=1, imm=7 → A=0, B=7.
  - issue rd=0 → no stall on later rd=0 op.
- Reset mid-op:
  - With pending[5]=1, out_valid=1 and ovf_sticky=1, assert reset between edges → all outputs 0 immediately.
  - After release, op reading r5 is accepted with A=0.
